// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

    // Encoding 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, reused by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell walks WIDTH-bit operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    full_adder u_fa (a_sh_q[0], b_sh_q[0], carry_q, fa_sum, fa_cout);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    carry_d  = bus.cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                carry_d  = fa_cout;
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The MSB bit is folded straight into the output registers.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 plus an exhaustive WIDTH=3 sweep.
// Overflow checks are compiled in only with SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(3)) bus3 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present operands and return at the negedge after the accept edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int guard;
        guard = 0;
        while (!bus8.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("start_ready", 32'(bus8.in_ready), 32'd1);
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = c;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic drain8();
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check("drain_idle_valid", 32'(bus8.out_valid), 32'd0);
        check("drain_idle_ready", 32'(bus8.in_ready), 32'd1);
    endtask

    int   cyc;
    logic seen;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.cin       = 1'b0;
        bus8.out_ready = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.a         = '0;
        bus3.b         = '0;
        bus3.cin       = 1'b0;
        bus3.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'h00);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        check("rst_busy", 32'(bus8.busy), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(bus8.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // FF + 01: wraps to 00 with carry-out, no signed overflow
        start8(8'hFF, 8'h01, 1'b0);
        check("t1_busy_run", 32'(bus8.busy), 32'd1);
        check("t1_ready_run", 32'(bus8.in_ready), 32'd0);
        wait_done8(cyc);
        check("t1_latency", 32'(cyc), 32'd8);
        check("t1_sum", 32'(bus8.sum), 32'h00);
        check("t1_cout", 32'(bus8.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        check("t1_ovf", 32'(bus8.ovf), 32'd0);
`endif
        check("t1_ready_done", 32'(bus8.in_ready), 32'd0);
        drain8();
        check("t1_hold_sum_idle", 32'(bus8.sum), 32'h00);
        check("t1_hold_cout_idle", 32'(bus8.cout), 32'd1);
        check("t1_busy_idle", 32'(bus8.busy), 32'd0);

        start8(8'h7F, 8'h01, 1'b0);
        wait_done8(cyc);
        check("t2a_latency", 32'(cyc), 32'd8);
        check("t2a_sum", 32'(bus8.sum), 32'h80);
        check("t2a_cout", 32'(bus8.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("t2a_ovf", 32'(bus8.ovf), 32'd1);
`endif
        drain8();

        start8(8'h80, 8'h80, 1'b0);
        wait_done8(cyc);
        check("t2b_sum", 32'(bus8.sum), 32'h00);
        check("t2b_cout", 32'(bus8.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        check("t2b_ovf", 32'(bus8.ovf), 32'd1);
`endif
        drain8();

        // Backpressure: 5A + 3C + 1 = 97, held while foreign operands are offered
        start8(8'h5A, 8'h3C, 1'b1);
        wait_done8(cyc);
        check("t3_latency", 32'(cyc), 32'd8);
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        bus8.cin = 1'b1;
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_bp_valid", 32'(bus8.out_valid), 32'd1);
            check("t3_bp_sum", 32'(bus8.sum), 32'h97);
            check("t3_bp_cout", 32'(bus8.cout), 32'd0);
            check("t3_bp_ready", 32'(bus8.in_ready), 32'd0);
        end
        bus8.in_valid = 1'b0;
        drain8();
        check("t3_no_accept", 32'(bus8.busy), 32'd0);
        check("t3_hold_sum", 32'(bus8.sum), 32'h97);

        // Reset during RUN cycle 4
        start8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_busy_pre", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 32'(bus8.out_valid), 32'd0);
        check("t4_rst_busy", 32'(bus8.busy), 32'd0);
        check("t4_rst_ready", 32'(bus8.in_ready), 32'd1);
        check("t4_rst_sum", 32'(bus8.sum), 32'h00);
        check("t4_rst_cout", 32'(bus8.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.out_valid) seen = 1'b1;
        end
        check("t4_no_valid", 32'(seen), 32'd0);
        start8(8'h12, 8'h34, 1'b1);
        wait_done8(cyc);
        check("t4_latency", 32'(cyc), 32'd8);
        check("t4_sum", 32'(bus8.sum), 32'h47);
        check("t4_cout", 32'(bus8.cout), 32'd0);
        drain8();

        // WIDTH=3 exhaustive sweep; junk operands stay offered while busy
        for (int v = 0; v < 128; v++) begin
            logic [6:0] vec;
            logic [3:0] exp3;
            int         guard;
            vec  = 7'(v);
            exp3 = 4'(vec[6:4]) + 4'(vec[3:1]) + 4'(vec[0]);
            guard = 0;
            while (!bus3.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            bus3.a        = vec[6:4];
            bus3.b        = vec[3:1];
            bus3.cin      = vec[0];
            bus3.in_valid = 1'b1;
            @(negedge clk);
            bus3.a   = ~vec[6:4];
            bus3.b   = vec[5:3];
            bus3.cin = ~vec[0];
            guard = 0;
            while (!bus3.out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("w3_sum", 32'({bus3.cout, bus3.sum}), 32'(exp3));
            guard = 0;
            forever begin
                logic r;
                r = (guard >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                bus3.out_ready = r;
                bus3.in_valid  = ~r;
                @(negedge clk);
                guard++;
                if (r) break;
            end
            bus3.out_ready = 1'b0;
            check("w3_no_accept", 32'(bus3.busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
